abc_change_logger: RTL and testbench

//   Synthesizable downstream consumer of the a/b/c observation bus. Samples a, b and c every

---
 rtl/abc_change_logger.sv | 97 +++++++++
 tb/tb_abc_change_logger.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/abc_change_logger.sv
// Change logger for the a/b/c observation bus: emits {ts, a, b, c, c_oe} records
// on the first sample and on every change, buffered in a show-ahead FIFO.
module abc_change_logger #(
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               a_i,
  input  logic               b_i,
  input  logic               c_i,
  input  logic               c_oe_i,
  output logic               rec_valid_o,
  input  logic               rec_ready_i,
  output logic [TS_W+3:0]    rec_data_o,
  output logic               ovf_o,
  output logic [DROP_W-1:0]  drop_cnt_o,
  input  logic               clr_ovf_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = TS_W + 4;

  logic [TS_W-1:0] ts_q;
  logic [3:0]      s_q;
  logic            first_q;
  logic            en_q;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;

  logic [3:0] v;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       wr_en;
  logic       drop;

  // c is stored as 0 while undriven, so activity on c_i during z is invisible
  assign v     = {a_i, b_i, c_i & c_oe_i, c_oe_i};
  assign push  = en_i & (first_q | ~en_q | (v != s_q));
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = ~empty & rec_ready_i;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign rec_valid_o = ~empty;
  assign rec_data_o  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      s_q     <= '0;
      first_q <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      s_q  <= v;
      en_q <= en_i;
      if (en_i) first_q <= 1'b0;
    end
  end

  // Storage needs no reset: pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ts_q, v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // A drop on the clearing edge is kept so it is not silently lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clr_ovf_i) begin
      ovf_o      <= drop;
      drop_cnt_o <= DROP_W'(drop);
    end else if (drop) begin
      ovf_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_abc_change_logger.sv
// Directed bench for abc_change_logger: hand-computed records captured at
// each accepted handshake and compared in order.
module tb_abc_change_logger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i, a_i, b_i, c_i, c_oe_i;
  logic        rec_valid_o, rec_ready_i;
  logic [19:0] rec_data_o;
  logic        ovf_o;
  logic [7:0]  drop_cnt_o;
  logic        clr_ovf_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          tcount   = 0;
  logic [31:0] got[$];

  abc_change_logger #(.TS_W(16), .DEPTH(8), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .c_oe_i(c_oe_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_data_o(rec_data_o), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o),
    .clr_ovf_i(clr_ovf_i)
  );

  always #5 clk = ~clk;

  // inputs change just after posedge, so negedge sees what the next edge will use
  always @(negedge clk) begin
    if (rst_n && rec_valid_o && rec_ready_i) got.push_back({12'd0, rec_data_o});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rec(input int t, input logic [3:0] v);
    logic [31:0] tv;
    tv = t;
    return {12'd0, tv[15:0], v};
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 32'hdead_beef;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  task automatic run_to(input int n);
    while (tcount < n) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    tcount = 0;
    got.delete();
  endtask

  int t0, t1, tx;

  initial begin
    rst_n = 1'b0; en_i = 1'b1; a_i = 1'b0; b_i = 1'b0; c_i = 1'b0; c_oe_i = 1'b1;
    rec_ready_i = 1'b1; clr_ovf_i = 1'b0;
    #1;
    check("rst_valid", 32'(rec_valid_o), 32'd0);
    check("rst_data",  32'(rec_data_o),  32'd0);
    check("rst_ovf",   32'(ovf_o),       32'd0);
    check("rst_cnt",   32'(drop_cnt_o),  32'd0);

    // 1: first sample logged at ts=0, then silence
    apply_reset();
    step();
    check("t1_valid_lat", 32'(rec_valid_o), 32'd1);
    check("t1_data_lat",  32'(rec_data_o),  rec(0, 4'b0001));
    repeat (9) step();
    check("t1_count", got.size(), 32'd1);
    check("t1_rec",   got_at(0), rec(0, 4'b0001));

    // 2: timed changes, incl. c toggling while undriven
    got.delete();
    run_to(100); a_i = 0; b_i = 1; c_i = 1;
    step();
    run_to(200); a_i = 1; b_i = 0; c_oe_i = 0;
    step();
    run_to(250); c_i = 0;
    step();
    run_to(260); c_i = 1;
    step();
    run_to(300); a_i = 1; b_i = 1; c_i = 0; c_oe_i = 1;
    step();
    repeat (5) step();
    check("t2_count", got.size(), 32'd3);
    check("t2_rec0", got_at(0), rec(100, 4'b0111));
    check("t2_rec1", got_at(1), rec(200, 4'b1000));
    check("t2_rec2", got_at(2), rec(300, 4'b1101));

    // 3: overflow with ready low
    got.delete();
    rec_ready_i = 0;
    t0 = tcount;
    for (int i = 0; i < 12; i++) begin
      a_i = ~a_i;
      step();
    end
    repeat (3) step();
    check("t3_valid", 32'(rec_valid_o), 32'd1);
    check("t3_ovf",   32'(ovf_o),       32'd1);
    check("t3_cnt",   32'(drop_cnt_o),  32'd4);
    check("t3_hold",  32'(rec_data_o),  rec(t0, 4'b0101));
    clr_ovf_i = 1; step(); clr_ovf_i = 0;
    check("t3_clr_ovf", 32'(ovf_o),      32'd0);
    check("t3_clr_cnt", 32'(drop_cnt_o), 32'd0);

    // 4: full + push + pop on one edge
    rec_ready_i = 1; a_i = 0; t1 = tcount;
    step();
    rec_ready_i = 0;
    check("t4_ovf", 32'(ovf_o),      32'd0);
    check("t4_cnt", 32'(drop_cnt_o), 32'd0);
    rec_ready_i = 1;
    repeat (12) step();
    check("t34_count", got.size(), 32'd9);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_drain%0d", i), got_at(i), rec(t0 + i, (i % 2 == 0) ? 4'b0101 : 4'b1101));
    check("t4_rec", got_at(8), rec(t1, 4'b0101));
    check("t34_empty", 32'(rec_valid_o), 32'd0);

    // 3b: clear coinciding with a drop
    rec_ready_i = 0;
    for (int i = 0; i < 9; i++) begin
      a_i = ~a_i;
      if (i == 8) clr_ovf_i = 1;
      step();
    end
    clr_ovf_i = 0;
    check("t3b_ovf", 32'(ovf_o),      32'd1);
    check("t3b_cnt", 32'(drop_cnt_o), 32'd1);
    rec_ready_i = 1;
    repeat (10) step();

    // 6: reset mid-drain with 5 queued
    got.delete();
    rec_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      a_i = ~a_i;
      step();
    end
    rec_ready_i = 1;
    step();
    #2 rst_n = 0;
    #1;
    check("t6_valid_async", 32'(rec_valid_o), 32'd0);
    check("t6_data_async",  32'(rec_data_o),  32'd0);
    a_i = 0; b_i = 1; c_i = 0; c_oe_i = 1; en_i = 1;
    apply_reset();
    repeat (5) step();
    check("t6_count", got.size(), 32'd1);
    check("t6_rec",   got_at(0), rec(0, 4'b0101));

    // 5: disabled logging, then enable at ts=50; then enable re-rise
    en_i = 0;
    apply_reset();
    for (int k = 0; k < 50; k++) begin
      a_i = k[0];
      step();
    end
    check("t5_none",  got.size(), 32'd0);
    check("t5_novld", 32'(rec_valid_o), 32'd0);
    a_i = 0; en_i = 1;
    step();
    repeat (5) step();
    check("t5_count", got.size(), 32'd1);
    check("t5_rec",   got_at(0), rec(50, 4'b0101));
    en_i = 0;
    repeat (3) step();
    en_i = 1; tx = tcount;
    step();
    repeat (3) step();
    check("t5_rise_count", got.size(), 32'd2);
    check("t5_rise_rec",   got_at(1), rec(tx, 4'b0101));

    // 7: timestamp wrap
    got.delete();
    run_to(65539);
    b_i = 0;
    step();
    repeat (4) step();
    check("t7_count", got.size(), 32'd1);
    check("t7_rec",   got_at(0), rec(3, 4'b0001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
